// File: rtl/aa_sync.sv
// Access-address correlator and byte framer between fsk_demod and the rx packet engine.
// Finds the AA within MAX_ERR bit errors, then packs header, payload and CRC bytes LSB-first.
module aa_sync #(
    parameter int MAX_ERR   = 1,
    parameter int MAX_LEN   = 37,
    parameter int SEARCH_TO = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [31:0] aa,
    input  logic        data_in,
    input  logic        data_in_valid,
    output logic        sync_found,
    output logic        locked,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        pkt_done,
    output logic        len_err,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, SEARCH, HEADER, PAYLOAD} state_t;

    state_t      state, state_d;
    logic [31:0] aa_q, aa_d, sr, sr_d, sr_shift, diff;
    logic [5:0]  fill, fill_d, fill_inc, errs;
    logic [11:0] search_cnt, search_cnt_d, search_inc;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [8:0]  byte_cnt, byte_cnt_d;
    logic [7:0]  len_q, len_d, acc, acc_d, acc_shift, byte_out_d;
    logic        match;
    logic        locked_d, sync_d, valid_d, done_d, len_err_d, timeout_d;

    assign sr_shift   = {data_in, sr[31:1]};
    assign acc_shift  = {data_in, acc[7:1]};
    assign fill_inc   = (fill == 6'd32) ? fill : fill + 6'd1;
    assign search_inc = search_cnt + 12'd1;

    // Correlate against the window that includes the bit arriving this cycle.
    always_comb begin
        diff = sr_shift ^ aa_q;
        errs = '0;
        for (int i = 0; i < 32; i++) begin
            errs = errs + {5'd0, diff[i]};
        end
    end

    assign match = (fill_inc == 6'd32) && (errs <= 6'(MAX_ERR));

    always_comb begin
        state_d      = state;
        aa_d         = aa_q;
        sr_d         = sr;
        fill_d       = fill;
        search_cnt_d = search_cnt;
        bit_cnt_d    = bit_cnt;
        byte_cnt_d   = byte_cnt;
        len_d        = len_q;
        acc_d        = acc;
        byte_out_d   = byte_out;
        locked_d     = locked;
        sync_d       = 1'b0;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        len_err_d    = 1'b0;
        timeout_d    = 1'b0;

        if (start) begin
            aa_d         = aa;
            sr_d         = '0;
            fill_d       = '0;
            search_cnt_d = '0;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            locked_d     = 1'b0;
            state_d      = SEARCH;
        end else if (data_in_valid) begin
            case (state)
                SEARCH: begin
                    sr_d         = sr_shift;
                    fill_d       = fill_inc;
                    search_cnt_d = search_inc;
                    if (match) begin
                        sync_d   = 1'b1;
                        locked_d = 1'b1;
                        state_d  = HEADER;
                    end else if (search_inc == 12'(SEARCH_TO)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                HEADER, PAYLOAD: begin
                    acc_d     = acc_shift;
                    bit_cnt_d = bit_cnt + 3'd1;
                    // Byte complete: byte_cnt still holds the index of the byte just finished.
                    if (bit_cnt == 3'd7) begin
                        valid_d    = 1'b1;
                        byte_out_d = acc_shift;
                        byte_cnt_d = byte_cnt + 9'd1;
                        if (state == HEADER) begin
                            if (byte_cnt == 9'd1) begin
                                len_d = acc_shift;
                                if (acc_shift > 8'(MAX_LEN)) begin
                                    len_err_d = 1'b1;
                                    locked_d  = 1'b0;
                                    state_d   = IDLE;
                                end else begin
                                    state_d = PAYLOAD;
                                end
                            end
                        end else if (byte_cnt == {1'b0, len_q} + 9'd4) begin
                            done_d   = 1'b1;
                            locked_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            aa_q       <= '0;
            sr         <= '0;
            fill       <= '0;
            search_cnt <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            len_q      <= '0;
            acc        <= '0;
            byte_out   <= '0;
            locked     <= 1'b0;
            sync_found <= 1'b0;
            byte_valid <= 1'b0;
            pkt_done   <= 1'b0;
            len_err    <= 1'b0;
            timeout    <= 1'b0;
        end else if (en) begin
            state      <= state_d;
            aa_q       <= aa_d;
            sr         <= sr_d;
            fill       <= fill_d;
            search_cnt <= search_cnt_d;
            bit_cnt    <= bit_cnt_d;
            byte_cnt   <= byte_cnt_d;
            len_q      <= len_d;
            acc        <= acc_d;
            byte_out   <= byte_out_d;
            locked     <= locked_d;
            sync_found <= sync_d;
            byte_valid <= valid_d;
            pkt_done   <= done_d;
            len_err    <= len_err_d;
            timeout    <= timeout_d;
        end
    end
endmodule
